// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised IEEE 754 add/subtract unit, multi-cycle, with a
// fixed latency and valid/ready handshakes on both sides.
//
// One operation is in flight at a time. It walks a six-state sequence:
// IDLE -> ALIGN -> ADD -> NORM -> RND -> DONE. The result is written on the
// edge that enters DONE, and out_valid rises one edge later. That puts
// out_valid 5 edges after the accept edge. Denormal inputs and results below
// the normal range flush to a signed zero.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b, op              operands in IEEE format; op=0 gives A+B, op=1 gives A-B
//   out_valid / out_ready result handshake (result is held until accepted)
//   result                IEEE result
//   flag_ovf              overflow; result is +/-Inf
//   flag_inv              invalid; result is qNaN
//   flag_zero             result is +/-0
//
// Build option:
//   FP_ROUND_RNE_EN  defined   : round to nearest, ties to even (guard/round/sticky)
//                    undefined : truncate toward zero
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_ovf,
  output logic                   flag_inv,
  output logic                   flag_zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_W + 2;          // signed working exponent
  localparam int LW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, RND, DONE} state_t;
  state_t state, next_state;

  // Captured operands (B already carries the op sign flip)
  logic [W-1:0]          a_r, b_r;
  // Working datapath registers shared across the stages
  logic                  sign_w, sub_w, zero_w, spec_w, spec_inv_w;
  logic [W-1:0]          spec_val_w;
  logic signed [EW-1:0]  exp_w;
  logic [MW:0]           man_w;      // extra MSB catches the addition carry
  logic [MW-1:0]         mb_w;

  function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
    logic [LW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LW'(1);
      end
    end
    return n;
  endfunction

  // ---------------- ALIGN combinational view ----------------
  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  assign {sa, ea, fa} = a_r;
  assign {sb, eb, fb} = b_r;

  logic                  a_nan, b_nan, a_inf, b_inf, a_ge, spec_s, spec_inv_s;
  logic [W-1:0]          spec_val_s;
  logic [MAN_W:0]        ma, mb, m_l, m_s;
  logic                  sign_l;
  logic [EXP_W-1:0]      exp_l, dexp;
  logic [MW-1:0]         ext_s, sh_s;

  // Unpack, classify, order by magnitude and align the smaller operand
  always_comb begin
    a_nan = (ea == EXP_ONES) && (fa != '0);
    b_nan = (eb == EXP_ONES) && (fb != '0);
    a_inf = (ea == EXP_ONES) && (fa == '0);
    b_inf = (eb == EXP_ONES) && (fb == '0);
    // Denormals (exponent field zero) are treated as exact zeros
    ma    = (ea == '0) ? '0 : {1'b1, fa};
    mb    = (eb == '0) ? '0 : {1'b1, fb};
    a_ge  = {ea, ma} >= {eb, mb};
    if (a_ge) begin
      sign_l = sa; exp_l = ea; m_l = ma; m_s = mb; dexp = ea - eb;
    end else begin
      sign_l = sb; exp_l = eb; m_l = mb; m_s = ma; dexp = eb - ea;
    end
    ext_s = {m_s, 3'b000};
    // Every bit shifted past the sticky position is ORed into it
    if (32'(dexp) >= MW) begin
      sh_s = {{(MW-1){1'b0}}, |m_s};
    end else begin
      sh_s = (ext_s >> dexp) |
             {{(MW-1){1'b0}}, |(ext_s & ~({MW{1'b1}} << dexp))};
    end
    spec_s = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & (sa != sb))) begin
      spec_val_s = QNAN;
      spec_inv_s = 1'b1;
    end else if (a_inf) begin
      spec_val_s = a_r;
      spec_inv_s = 1'b0;
    end else if (b_inf) begin
      spec_val_s = b_r;
      spec_inv_s = 1'b0;
    end else begin
      spec_val_s = '0;
      spec_inv_s = 1'b0;
    end
  end

  // ---------------- NORM / RND combinational view ----------------
  logic [LW-1:0]         lz;
  logic signed [EW-1:0]  exp_dec, exp_fin;
  logic                  up;
  logic [MAN_W+1:0]      rsum;
  logic [MAN_W-1:0]      frac_fin;

  // Leading-zero shift amount and rounding of the normalised mantissa
  always_comb begin
    lz      = lzc(man_w[MW-1:0]);
    exp_dec = exp_w - $signed(EW'(lz));
`ifdef FP_ROUND_RNE_EN
    up = man_w[2] & (man_w[1] | man_w[0] | man_w[3]);
`else
    up = 1'b0;
`endif
    rsum     = {1'b0, man_w[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    exp_fin  = exp_w + $signed(EW'(rsum[MAN_W+1]));
    // A rounding carry means the mantissa became 10.00..0: fraction is zero
    frac_fin = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = ALIGN;
               else                      next_state = IDLE;
      ALIGN:   next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    next_state = RND;
      RND:     next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
               else                        next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Registered handshake outputs; out_valid follows entry into DONE by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (state == DONE) && (next_state == DONE);
    end
  end

  // Operand capture and per-stage datapath updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      sign_w     <= 1'b0;
      sub_w      <= 1'b0;
      zero_w     <= 1'b0;
      spec_w     <= 1'b0;
      spec_inv_w <= 1'b0;
      spec_val_w <= '0;
      exp_w      <= '0;
      man_w      <= '0;
      mb_w       <= '0;
      result     <= '0;
      flag_ovf   <= 1'b0;
      flag_inv   <= 1'b0;
      flag_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r <= a;
            b_r <= {b[W-1] ^ op, b[W-2:0]};
          end
        end
        ALIGN: begin
          sign_w     <= sign_l;
          exp_w      <= $signed({2'b00, exp_l});
          man_w      <= {1'b0, m_l, 3'b000};
          mb_w       <= sh_s;
          sub_w      <= sa ^ sb;
          spec_w     <= spec_s;
          spec_inv_w <= spec_inv_s;
          spec_val_w <= spec_val_s;
          zero_w     <= 1'b0;
        end
        ADD: begin
          if (sub_w) begin
            man_w <= man_w - {1'b0, mb_w};
            // Exact cancellation always gives +0
            if (man_w[MW-1:0] == mb_w) sign_w <= 1'b0;
          end else begin
            man_w <= man_w + {1'b0, mb_w};
          end
        end
        NORM: begin
          if (man_w[MW]) begin
            man_w <= {1'b0, man_w[MW:2], man_w[1] | man_w[0]};
            exp_w <= exp_w + $signed(EW'(1));
          end else if (man_w == '0) begin
            zero_w <= 1'b1;
          end else if (exp_dec <= $signed(EW'(0))) begin
            zero_w <= 1'b1;
          end else begin
            man_w <= man_w << lz;
            exp_w <= exp_dec;
          end
        end
        RND: begin
          if (spec_w) begin
            result    <= spec_val_w;
            flag_inv  <= spec_inv_w;
            flag_ovf  <= 1'b0;
            flag_zero <= 1'b0;
          end else if (zero_w) begin
            result    <= {sign_w, {(W-1){1'b0}}};
            flag_inv  <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_zero <= 1'b1;
          end else if (exp_fin >= $signed({2'b00, EXP_ONES})) begin
            result    <= {sign_w, EXP_ONES, {MAN_W{1'b0}}};
            flag_inv  <= 1'b0;
            flag_ovf  <= 1'b1;
            flag_zero <= 1'b0;
          end else begin
            result    <= {sign_w, exp_fin[EXP_W-1:0], frac_fin};
            flag_inv  <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (EXP_W=8, MAN_W=23). The reference
// model computes the exact sum of the two operands as a wide integer. It then
// rounds that sum according to the build option.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        in_ready, out_valid, flag_ovf, flag_inv, flag_zero;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_ovf(flag_ovf), .flag_inv(flag_inv),
    .flag_zero(flag_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Exact reference: fl = {ovf, inv, zero}
  function automatic void ref_model(input logic [31:0] xa, input logic [31:0] xb_in,
                                    input logic xop, output logic [31:0] res,
                                    output logic [2:0] fl);
    logic [31:0]  xb;
    logic         sa, sb, s, up;
    int           ea, eb, p, e, sh;
    logic [22:0]  fa, fb;
    logic [299:0] va, vb, mag;
    logic [24:0]  top;
    xb = xb_in ^ (xop ? 32'h8000_0000 : 32'h0);
    sa = xa[31]; ea = int'(xa[30:23]); fa = xa[22:0];
    sb = xb[31]; eb = int'(xb[30:23]); fb = xb[22:0];
    res = 32'h0; fl = 3'b000;
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) begin
      res = 32'h7FC0_0000; fl = 3'b010;
    end else if (ea == 255 && eb == 255) begin
      if (sa != sb) begin res = 32'h7FC0_0000; fl = 3'b010; end
      else res = xa;
    end else if (ea == 255) begin
      res = xa;
    end else if (eb == 255) begin
      res = xb;
    end else begin
      // value = v * 2^-149, denormals count as zero
      va = (ea == 0) ? 300'd0 : (300'({1'b1, fa}) << (ea - 1));
      vb = (eb == 0) ? 300'd0 : (300'({1'b1, fb}) << (eb - 1));
      if (sa == sb)      begin mag = va + vb; s = sa; end
      else if (va >= vb) begin mag = va - vb; s = sa; end
      else               begin mag = vb - va; s = sb; end
      if (mag == 300'd0) begin
        res = {(sa == sb) ? sa : 1'b0, 31'h0}; fl = 3'b001;
      end else begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) begin
          res = {s, 31'h0}; fl = 3'b001;
        end else begin
          sh  = p - 23;
          top = 25'(mag >> sh);
          up  = 1'b0;
`ifdef FP_ROUND_RNE_EN
          if (sh > 0) begin
            logic [299:0] rem, half;
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            up   = (rem > half) || ((rem == half) && top[0]);
          end
`endif
          top = top + 25'(up);
          if (top[24]) begin top = top >> 1; e = e + 1; end
          if (e >= 255) begin res = {s, 8'hFF, 23'h0}; fl = 3'b100; end
          else          res = {s, 8'(e), top[22:0]};
        end
      end
    end
  endfunction

  // One transaction: accept, latency check, model compare, optional hold, drain
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                        input int hold, output logic [31:0] res, output logic [2:0] fl);
    int          waited, edges;
    logic [31:0] mres;
    logic [2:0]  mfl;
    waited = 0;
    while (!in_ready && waited < 20) begin @(negedge clk); waited++; end
    check_eq("in_ready_wait", {31'h0, in_ready}, 32'd1);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Junk offered while busy must be ignored
    a = $urandom; b = $urandom; op = 1'($urandom);
    check_eq("in_ready_busy", {31'h0, in_ready}, 32'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
    in_valid = 1'b0;
    check_eq("latency", edges, 32'd5);
    res = result;
    fl  = {flag_ovf, flag_inv, flag_zero};
    ref_model(ia, ib, iop, mres, mfl);
    check_eq("result", res, mres);
    check_eq("flags", {29'h0, fl}, {29'h0, mfl});
    check_eq("in_ready_done", {31'h0, in_ready}, 32'd0);
    repeat (hold) begin
      @(negedge clk);
      check_eq("hold_result", result, res);
      check_eq("hold_flags", {29'h0, flag_ovf, flag_inv, flag_zero}, {29'h0, fl});
      check_eq("hold_valid", {31'h0, out_valid}, 32'd1);
      check_eq("hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("valid_cleared", {31'h0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] with_exp(input logic [31:0] x, input int e);
    int ec;
    ec = (e < 0) ? 0 : ((e > 255) ? 255 : e);
    return {1'($urandom), 8'(ec), 23'($urandom)};
  endfunction

  typedef struct {
    logic [31:0] va, vb;
    logic        vop;
    logic [31:0] vr;
    logic [2:0]  vf;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] specials[7];

  initial begin
    logic [31:0] r, ra, rb, tmp;
    logic [2:0]  f;
    logic        rop;
    int          mode;

    vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0, 32'h40C0_0000, 3'b000};
    vecs[1]  = '{32'h40E0_0000, 32'h4000_0000, 1'b1, 32'h40A0_0000, 3'b000};
    vecs[2]  = '{32'h4120_0000, 32'hC000_0000, 1'b0, 32'h4100_0000, 3'b000};
    vecs[3]  = '{32'h40A0_0000, 32'h40A0_0000, 1'b1, 32'h0000_0000, 3'b001};
    vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b010};
    vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100};
`ifdef FP_ROUND_RNE_EN
    vecs[6]  = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 3'b000};
`else
    vecs[6]  = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0000, 3'b000};
`endif
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b001};
    vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b010};
    vecs[9]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 3'b000};
    vecs[10] = '{32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[11] = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000};
    vecs[12] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3'b001};
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h0000_0001, 32'h7F7F_FFFF};

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {29'h0, flag_ovf, flag_inv, flag_zero}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", {31'h0, in_ready}, 32'd1);

    // Directed vectors; the first one also holds out_ready low in DONE
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, (i == 0) ? 4 : 0, r, f);
      check_eq($sformatf("dir%0d_result", i), r, vecs[i].vr);
      check_eq($sformatf("dir%0d_flags", i), {29'h0, f}, {29'h0, vecs[i].vf});
    end

    // Reset pulse while the operation sits in NORM
    while (!in_ready) @(negedge clk);
    a = 32'h4080_0000; b = 32'h4000_0000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'h0, in_ready}, 32'd0);
    check_eq("midrst_result", result, 32'h0);
    check_eq("midrst_flags", {29'h0, flag_ovf, flag_inv, flag_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_rel_in_ready", {31'h0, in_ready}, 32'd1);
    repeat (8) begin
      @(negedge clk);
      check_eq("midrst_discarded", {31'h0, out_valid}, 32'd0);
    end

    // Randomised operations against the reference model
    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 9));
      ra   = $urandom;
      rop  = 1'($urandom);
      case (mode)
        0, 1, 2: rb = with_exp(ra, int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3);
        3: begin
          ra[30:23] = 8'($urandom_range(1, 4));
          rb = with_exp(ra, int'(ra[30:23]) + int'($urandom_range(0, 4)) - 2);
        end
        4: rb = ra;
        5: rb = ra ^ 32'($urandom_range(1, 15));
        6: rb = with_exp(ra, int'(ra[30:23]) - int'($urandom_range(20, 30)));
        7: begin
          rb = specials[$urandom_range(0, 6)];
          if ($urandom_range(0, 1) == 1) begin tmp = ra; ra = rb; rb = tmp; end
        end
        default: rb = $urandom;
      endcase
      run_op(ra, rb, rop, 0, r, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
